// File: rtl/bf8b_pkg.sv
// Shared types for the memory arbiter.
//   state_t : arbiter control states (IDLE / BUSY / DONE)
//   gnt_t   : requester identifiers used for the grant and the round-robin memory
package bf8b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_EXEC  = 1'b1
  } gnt_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way round-robin tie-break (combinational).
//   req0  : fetch request
//   req1  : exec request
//   last  : requester granted most recently
//   grant : chosen requester; only meaningful when req0 or req1 is high
module arb_pick2
  import bf8b_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  gnt_t last,
  output gnt_t grant
);

  always_comb begin
    grant = GNT_FETCH;
    if (req0 && req1) begin
      // On a tie, the requester that did not win last time goes first.
      grant = (last == GNT_FETCH) ? GNT_EXEC : GNT_FETCH;
    end else if (req1) begin
      grant = GNT_EXEC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch (read-only) port and an exec (read/write) port onto one
// shared memory port, one transaction at a time, with round-robin tie-break.
//   clk, rst_n                               : clock, async active-low reset
//   fetch_req/addr -> fetch_ready/data       : fetch read port
//   exec_req/addr/we/wdata -> exec_ready/rdata: exec read/write port
//   mem_req/addr/we/data_out <- mem_data_in/mem_ready : shared memory port
//   busy                                     : high whenever not IDLE
module mem_arbiter
  import bf8b_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              exec_req,
  input  logic [ADDR_W-1:0] exec_addr,
  input  logic              exec_we,
  input  logic [DATA_W-1:0] exec_wdata,
  output logic              exec_ready,
  output logic [DATA_W-1:0] exec_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready,
  output logic              busy
);

  state_t state, state_nxt;
  gnt_t   gnt, gnt_nxt;
  gnt_t   last, last_nxt;
  gnt_t   pick;

  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_data_out_nxt;
  logic              fetch_ready_nxt, exec_ready_nxt;
  logic [DATA_W-1:0] fetch_data_nxt, exec_rdata_nxt;
  logic              gnt_req;

  arb_pick2 u_pick (
    .req0  (fetch_req),
    .req1  (exec_req),
    .last  (last),
    .grant (pick)
  );

  assign busy    = (state != ST_IDLE);
  assign gnt_req = (gnt == GNT_FETCH) ? fetch_req : exec_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gnt          <= GNT_FETCH;
      last         <= GNT_FETCH;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_data_out <= '0;
      fetch_ready  <= 1'b0;
      exec_ready   <= 1'b0;
      fetch_data   <= '0;
      exec_rdata   <= '0;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      last         <= last_nxt;
      mem_req      <= mem_req_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_we       <= mem_we_nxt;
      mem_data_out <= mem_data_out_nxt;
      fetch_ready  <= fetch_ready_nxt;
      exec_ready   <= exec_ready_nxt;
      fetch_data   <= fetch_data_nxt;
      exec_rdata   <= exec_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    gnt_nxt          = gnt;
    last_nxt         = last;
    mem_req_nxt      = mem_req;
    mem_addr_nxt     = mem_addr;
    mem_we_nxt       = mem_we;
    mem_data_out_nxt = mem_data_out;
    fetch_ready_nxt  = fetch_ready;
    exec_ready_nxt   = exec_ready;
    fetch_data_nxt   = fetch_data;
    exec_rdata_nxt   = exec_rdata;

    unique case (state)
      ST_IDLE: begin
        if (fetch_req || exec_req) begin
          gnt_nxt     = pick;
          mem_req_nxt = 1'b1;
          state_nxt   = ST_BUSY;
          if (pick == GNT_FETCH) begin
            mem_addr_nxt     = fetch_addr;
            mem_we_nxt       = 1'b0;
            mem_data_out_nxt = '0;
          end else begin
            mem_addr_nxt     = exec_addr;
            mem_we_nxt       = exec_we;
            mem_data_out_nxt = exec_wdata;
          end
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          mem_req_nxt = 1'b0;
          if (gnt_req) begin
            state_nxt = ST_DONE;
            if (gnt == GNT_FETCH) begin
              fetch_ready_nxt = 1'b1;
              fetch_data_nxt  = mem_data_in;
            end else begin
              exec_ready_nxt = 1'b1;
              if (!mem_we) exec_rdata_nxt = mem_data_in;
            end
          end else begin
            // Requester gave up mid-transaction: finish silently, but the
            // memory slot was still consumed, so it counts as the last grant.
            state_nxt = ST_IDLE;
            last_nxt  = gnt;
          end
        end
      end

      ST_DONE: begin
        if (!gnt_req) begin
          fetch_ready_nxt = 1'b0;
          exec_ready_nxt  = 1'b0;
          last_nxt        = gnt;
          state_nxt       = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ready;
  logic [7:0] fetch_data;
  logic       exec_req;
  logic [7:0] exec_addr;
  logic       exec_we;
  logic [7:0] exec_wdata;
  logic       exec_ready;
  logic [7:0] exec_rdata;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_data_out;
  logic [7:0] mem_data_in;
  logic       mem_ready;
  logic       busy;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .fetch_data   (fetch_data),
    .exec_req     (exec_req),
    .exec_addr    (exec_addr),
    .exec_we      (exec_we),
    .exec_wdata   (exec_wdata),
    .exec_ready   (exec_ready),
    .exec_rdata   (exec_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 8'h00;
    exec_req = 1'b0; exec_addr = 8'h00; exec_we = 1'b0; exec_wdata = 8'h00;
    mem_data_in = 8'h00; mem_ready = 1'b0;
    #3;
    chk("rst_mem_req",  32'(mem_req), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_fready",   32'(fetch_ready), 32'd0);
    chk("rst_eready",   32'(exec_ready), 32'd0);
    chk("rst_fdata",    32'(fetch_data), 32'd0);
    chk("rst_erdata",   32'(exec_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fetch-only read, memory answers two cycles after mem_req
    fetch_req = 1'b1; fetch_addr = 8'h10;
    tick();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", 32'(mem_addr), 32'h10);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    chk("f_mem_dout", 32'(mem_data_out), 32'd0);
    chk("f_busy", 32'(busy), 32'd1);
    tick();
    chk("f_wait_ready", 32'(fetch_ready), 32'd0);
    mem_ready = 1'b1; mem_data_in = 8'hA5;
    tick();
    mem_ready = 1'b0;
    chk("f_mem_req_fall", 32'(mem_req), 32'd0);
    chk("f_ready", 32'(fetch_ready), 32'd1);
    chk("f_data", 32'(fetch_data), 32'hA5);
    chk("f_eready", 32'(exec_ready), 32'd0);
    tick();
    chk("f_ready_hold", 32'(fetch_ready), 32'd1);
    fetch_req = 1'b0;
    tick();
    chk("f_ready_fall", 32'(fetch_ready), 32'd0);
    chk("f_idle", 32'(busy), 32'd0);

    // Exec write
    exec_req = 1'b1; exec_we = 1'b1; exec_addr = 8'h20; exec_wdata = 8'h3C;
    tick();
    chk("w_mem_req", 32'(mem_req), 32'd1);
    chk("w_mem_addr", 32'(mem_addr), 32'h20);
    chk("w_mem_we", 32'(mem_we), 32'd1);
    chk("w_mem_dout", 32'(mem_data_out), 32'h3C);
    mem_ready = 1'b1; mem_data_in = 8'hEE;
    tick();
    mem_ready = 1'b0;
    chk("w_eready", 32'(exec_ready), 32'd1);
    chk("w_fready", 32'(fetch_ready), 32'd0);
    chk("w_mem_req_fall", 32'(mem_req), 32'd0);
    chk("w_rdata_unchanged", 32'(exec_rdata), 32'd0);
    exec_req = 1'b0; exec_we = 1'b0;
    tick();
    chk("w_eready_fall", 32'(exec_ready), 32'd0);
    chk("w_idle", 32'(busy), 32'd0);

    // Ties after a fresh reset: E,F,E,F
    rst_n = 1'b0; #2; rst_n = 1'b1;
    fetch_req = 1'b1; fetch_addr = 8'h11;
    exec_req  = 1'b1; exec_addr  = 8'h22; exec_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_mem_req", 32'(mem_req), 32'd1);
      chk("rr_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h22 : 32'h11);
      mem_ready = 1'b1; mem_data_in = 8'(8'h40 + i);
      tick();
      mem_ready = 1'b0;
      if (i % 2 == 0) begin
        chk("rr_eready", 32'(exec_ready), 32'd1);
        chk("rr_fready", 32'(fetch_ready), 32'd0);
        chk("rr_erdata", 32'(exec_rdata), 32'h40 + 32'(i));
        exec_req = 1'b0;
      end else begin
        chk("rr_fready", 32'(fetch_ready), 32'd1);
        chk("rr_eready", 32'(exec_ready), 32'd0);
        chk("rr_fdata", 32'(fetch_data), 32'h40 + 32'(i));
        chk("rr_erdata_hold", 32'(exec_rdata), 32'h40 + 32'(i) - 32'd1);
        fetch_req = 1'b0;
      end
      tick();
      // DONE exit cycle: the other pending request must not start yet
      chk("rr_no_accept", 32'(mem_req), 32'd0);
      chk("rr_ready_low", 32'(fetch_ready | exec_ready), 32'd0);
      fetch_req = 1'b1; exec_req = 1'b1;
    end
    fetch_req = 1'b0; exec_req = 1'b0;
    tick();

    // Fetch abandons mid-BUSY while exec waits
    fetch_req = 1'b1; fetch_addr = 8'h33;
    tick();
    chk("ab_mem_req", 32'(mem_req), 32'd1);
    chk("ab_addr", 32'(mem_addr), 32'h33);
    fetch_req = 1'b0;
    exec_req = 1'b1; exec_addr = 8'h44; exec_we = 1'b0;
    tick();
    chk("ab_busy", 32'(busy), 32'd1);
    chk("ab_addr_hold", 32'(mem_addr), 32'h33);
    mem_ready = 1'b1; mem_data_in = 8'h99;
    tick();
    mem_ready = 1'b0;
    chk("ab_busy_fall", 32'(busy), 32'd0);
    chk("ab_fready", 32'(fetch_ready), 32'd0);
    chk("ab_fdata_hold", 32'(fetch_data), 32'h43);
    chk("ab_mem_req_fall", 32'(mem_req), 32'd0);
    tick();
    chk("ab_exec_next", 32'(mem_addr), 32'h44);
    chk("ab_exec_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_data_in = 8'h55;
    tick();
    mem_ready = 1'b0;
    chk("ab_eready", 32'(exec_ready), 32'd1);
    chk("ab_erdata", 32'(exec_rdata), 32'h55);
    exec_req = 1'b0;
    tick();

    // Stray mem_ready in IDLE
    mem_ready = 1'b1; mem_data_in = 8'h77;
    tick();
    mem_ready = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_ready", 32'(fetch_ready | exec_ready), 32'd0);
    chk("stray_data", 32'(exec_rdata), 32'h55);

    // Reset during BUSY, then a tie goes to exec
    fetch_req = 1'b1; fetch_addr = 8'h11;
    exec_req  = 1'b1; exec_addr  = 8'h22;
    tick();
    chk("rb_mem_req", 32'(mem_req), 32'd1);
    chk("rb_winner_f", 32'(mem_addr), 32'h11);
    rst_n = 1'b0;
    #1;
    chk("rb_mem_req_async", 32'(mem_req), 32'd0);
    chk("rb_busy_async", 32'(busy), 32'd0);
    chk("rb_ready_async", 32'(fetch_ready | exec_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rb_restart", 32'(mem_req), 32'd1);
    chk("rb_exec_wins", 32'(mem_addr), 32'h22);
    mem_ready = 1'b1; mem_data_in = 8'h66;
    tick();
    mem_ready = 1'b0;
    chk("rb_eready", 32'(exec_ready), 32'd1);
    fetch_req = 1'b0; exec_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the memory data width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_req  in  1  SHALL be the fetch read request, held high until fetch_ready is seen.
REQ-006 fetch_addr  in  ADDR_W  SHALL be the fetch address, stable while fetch_req is high.
REQ-007 fetch_ready  out  1  SHALL indicate fetch completion.
REQ-008 fetch_data  out  DATA_W  SHALL carry fetch read data.
REQ-009 exec_req  in  1  SHALL be the exec request, held high until exec_ready is seen.
REQ-010 exec_addr, exec_we, exec_wdata  in  ADDR_W/1/DATA_W  SHALL be the exec address, write-enable and write data.
REQ-011 exec_ready  out  1  SHALL indicate exec completion.
REQ-012 exec_rdata  out  DATA_W  SHALL carry exec read data.
REQ-013 mem_req, mem_addr, mem_we, mem_data_out  out  1/ADDR_W/1/DATA_W  SHALL drive the shared memory port.
REQ-014 mem_data_in, mem_ready  in  DATA_W/1  SHALL be memory read data and completion.
REQ-015 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-016 Control SHALL use states IDLE, BUSY and DONE.
REQ-017 IDLE: with any request sampled high, the arbiter SHALL latch the winner's addr/we/wdata, assert mem_req, and enter BUSY on the same edge, so mem_req is visible one cycle after the request.
REQ-018 With only one request high, that requester SHALL win.
REQ-019 With both requests high in IDLE, the winner SHALL be the requester not granted last (round-robin).
REQ-020 Fetch transactions SHALL drive mem_we=0 and mem_data_out=0.
REQ-021 mem_addr, mem_we and mem_data_out SHALL stay constant from entry to BUSY until mem_req falls.
REQ-022 BUSY: on mem_ready sampled high, mem_req SHALL fall, the granted ready SHALL rise, and for a read the rdata output SHALL capture mem_data_in; all on the same edge, with the next state DONE.
REQ-023 DONE: ready SHALL be held high until the granted req is sampled low; then ready SHALL fall, last-grant SHALL update, and the state SHALL return to IDLE.
REQ-024 A new request SHALL NOT be accepted in the cycle DONE exits; minimum spacing between two mem_req assertions is 3 cycles.
REQ-025 If the granted req falls during BUSY, the memory transaction SHALL complete, and on mem_ready no ready SHALL be raised and the state SHALL go directly to IDLE.
REQ-026 mem_ready outside BUSY SHALL be ignored.
REQ-027 The non-granted requester SHALL see ready=0 and unchanged rdata throughout.
REQ-028 rdata outputs SHALL hold their last captured value until the next read completes for that requester.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, every output to 0, and last-grant to FETCH (so the first tie goes to exec).
REQ-030 Reset during BUSY SHALL abandon the memory transaction; mem_req falls asynchronously.

Structure
REQ-031 The state enum and the grant IDs GNT_FETCH/GNT_EXEC SHALL reside in the shared package bf8b_pkg.
REQ-032 The tie-break logic SHALL be a combinational sub-module arb_pick2 (inputs req0, req1, last; output grant); everything else lives in mem_arbiter.

Verification
REQ-033 Fetch-only read: fetch_req=1, addr 0x10, memory returns 0xA5 after 2 cycles -> mem_req one cycle after request, mem_addr=0x10, mem_we=0, fetch_data=0xA5, fetch_ready high until fetch_req drops.
REQ-034 Exec write: exec_we=1, addr 0x20, wdata 0x3C -> mem_we=1, mem_data_out=0x3C, exec_ready rises on the mem_ready edge; fetch_ready stays 0.
REQ-035 Simultaneous requests after reset -> exec granted first, then fetch; repeating both -> grants alternate E,F,E,F.
REQ-036 fetch_req dropped mid-BUSY, mem_ready two cycles later -> fetch_ready never rises, busy falls on the mem_ready edge, and a pending exec_req is granted next.
REQ-037 rst_n pulsed low during BUSY -> mem_req, busy and all ready outputs go 0 before the next clk edge; the next request starts normally, with exec winning a tie.
